fibonacci_seq: RTL and testbench
================================

Name: fibonacci_seq

Overview:
Parametrised successor to fibonacci_top. Computes F(n) on request, with a start/busy/done handshake, modulo-2^WIDTH result and overflow flag, and an optional streaming mode that emits every term F(0)..F(n). Sits as a compute peripheral driven by a controller or testbench. Convention: F(0)=0, F(1)=1.

Parameters:
WIDTH, 8, result width in bits; arithmetic is modulo 2^WIDTH.
N_WIDTH, 8, width of the requested index n.
STREAM, 0, 0 = final-result mode; 1 = emit every intermediate term with term_valid.

Ports:
clock  input  1  rising-edge clock.
reset  input  1  asynchronous, active-low reset.
start  input  1  request pulse; sampled only in IDLE.
n  input  N_WIDTH  index requested; latched when start is accepted.
busy  output  1  high from acceptance through the done cycle.
done  output  1  one-cycle pulse; fibonacci holds F(n) mod 2^WIDTH.
fibonacci  output  WIDTH  result, or current term in STREAM mode; holds its value between requests.
term_valid  output  1  STREAM=1: one-cycle pulse per emitted term. Tied 0 when STREAM=0.
term_index  output  N_WIDTH  index of the term on fibonacci while term_valid is high.
overflow  output  1  valid with done/term_valid: true value of that term >= 2^WIDTH.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE. busy, done, fibonacci, term_valid, term_index and overflow are all 0. Internal a, b, idx, n_lat and overflow trackers are cleared. A reset mid-computation aborts immediately, with no done pulse.
- FSM states: IDLE, CALC, DONE.
- IDLE: when start=1 at an edge: n_lat<=n, a<=0, b<=1, idx<=0, a_ovf<=0, b_ovf<=0, busy<=1, next state CALC.
- CALC, each edge:
  - If STREAM=1: term_valid<=1, term_index<=idx, fibonacci<=a, overflow<=a_ovf.
  - If idx==n_lat: fibonacci<=a, overflow<=a_ovf, done<=1, next state DONE.
  - Else: a<=b, b<=(a+b) mod 2^WIDTH, a_ovf<=b_ovf, b_ovf<=a_ovf|b_ovf|carry(a+b), idx<=idx+1.
- DONE: done<=0, term_valid<=0, busy<=0, next state IDLE. start is ignored in this cycle.
- Latency: done is high in the cycle after the (n+1)th edge following the accepting edge. Example: n=10 gives done 11 clocks after acceptance.
- STREAM=1 emits exactly n+1 term pulses, indices 0..n contiguous. The last pulse coincides with done.
- start while busy (CALC or DONE) is ignored. n changing while busy has no effect.
- Overflow is sticky through the sequence. Once any term exceeds the range, all later terms flag overflow. fibonacci always carries the low WIDTH bits.
- n=0: single CALC cycle, result 0.
- Maximum n = 2^N_WIDTH-1. idx never wraps because compare happens before increment.
- Outputs are registered; no combinational path from inputs to outputs.

Test Plan:
- WIDTH=8, STREAM=0: reset low for 10ns then high; start pulse with n=10 -> done after 11 clocks, fibonacci=55, overflow=0, busy low in the next cycle.
- Boundaries: n=0 -> 0 after 1 clock; n=1 -> 1 after 2 clocks; n=2 -> 1 after 3 clocks; n=13 -> 233 with overflow=0.
- Overflow: n=14 -> fibonacci=121 (377 mod 256), overflow=1. n=20 -> fibonacci=6765 mod 256=109, overflow=1.
- STREAM=1, n=5: term_valid for 6 consecutive cycles.
  - term_index 0..5, fibonacci 0,1,1,2,3,5.
  - done coincides with index 5.
  - term_valid low afterwards.
- Handshake: assert start again during CALC and during the DONE cycle with n=3 -> ignored, original n=10 result 55 delivered. start in the following IDLE cycle is accepted.
- Reset mid-operation: pull reset low 4 clocks into n=10 -> all outputs 0 immediately, no done pulse. After release, a new n=7 request -> 13.

Source files
------------

// File: rtl/fibonacci_seq.sv
// Iterative Fibonacci peripheral: start/busy/done handshake, modulo-2^WIDTH result
// with sticky overflow, and an optional per-term streaming output.
module fibonacci_seq #(
   parameter int WIDTH   = 8,
   parameter int N_WIDTH = 8,
   parameter int STREAM  = 0
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               start,
   input  logic [N_WIDTH-1:0] n,
   output logic               busy,
   output logic               done,
   output logic [WIDTH-1:0]   fibonacci,
   output logic               term_valid,
   output logic [N_WIDTH-1:0] term_index,
   output logic               overflow
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t             state;
   logic [WIDTH-1:0]   a;
   logic [WIDTH-1:0]   b;
   logic               a_ovf;
   logic               b_ovf;
   logic [N_WIDTH-1:0] idx;
   logic [N_WIDTH-1:0] n_lat;

   // One extra bit so the carry out of the modulo add feeds the overflow tracker.
   logic [WIDTH:0]     sum;
   assign sum = {1'b0, a} + {1'b0, b};

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state      <= IDLE;
         a          <= '0;
         b          <= '0;
         a_ovf      <= 1'b0;
         b_ovf      <= 1'b0;
         idx        <= '0;
         n_lat      <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
         fibonacci  <= '0;
         term_valid <= 1'b0;
         term_index <= '0;
         overflow   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  n_lat <= n;
                  a     <= '0;
                  b     <= {{(WIDTH-1){1'b0}}, 1'b1};
                  idx   <= '0;
                  a_ovf <= 1'b0;
                  b_ovf <= 1'b0;
                  busy  <= 1'b1;
                  state <= CALC;
               end
            end

            CALC: begin
               if (STREAM != 0) begin
                  term_valid <= 1'b1;
                  term_index <= idx;
                  fibonacci  <= a;
                  overflow   <= a_ovf;
               end
               // Compare before incrementing, so idx stops at n_lat and never wraps.
               if (idx == n_lat) begin
                  fibonacci <= a;
                  overflow  <= a_ovf;
                  done      <= 1'b1;
                  state     <= DONE;
               end else begin
                  a     <= b;
                  b     <= sum[WIDTH-1:0];
                  a_ovf <= b_ovf;
                  b_ovf <= a_ovf | b_ovf | sum[WIDTH];
                  idx   <= idx + 1'b1;
               end
            end

            DONE: begin
               done       <= 1'b0;
               term_valid <= 1'b0;
               busy       <= 1'b0;
               state      <= IDLE;
            end

            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fibonacci_seq.sv
// Randomised self-checking bench for fibonacci_seq: one final-result instance and one
// streaming instance, both checked against a saturating arithmetic reference.
module tb_fibonacci_seq;

   localparam int W  = 8;
   localparam int NW = 8;

   logic          clock = 1'b0;
   logic          reset = 1'b0;
   logic          start = 1'b0;
   logic [NW-1:0] n     = '0;
   logic          busy, done, term_valid, overflow;
   logic [W-1:0]  fibonacci;
   logic [NW-1:0] term_index;

   logic          start_s = 1'b0;
   logic [NW-1:0] n_s     = '0;
   logic          busy_s, done_s, term_valid_s, overflow_s;
   logic [W-1:0]  fibonacci_s;
   logic [NW-1:0] term_index_s;

   int checks = 0;
   int errors = 0;

   always #5 clock = ~clock;

   fibonacci_seq #(.WIDTH(W), .N_WIDTH(NW), .STREAM(0)) dut (
      .clock(clock), .reset(reset), .start(start), .n(n),
      .busy(busy), .done(done), .fibonacci(fibonacci),
      .term_valid(term_valid), .term_index(term_index), .overflow(overflow)
   );

   fibonacci_seq #(.WIDTH(W), .N_WIDTH(NW), .STREAM(1)) dut_s (
      .clock(clock), .reset(reset), .start(start_s), .n(n_s),
      .busy(busy_s), .done(done_s), .fibonacci(fibonacci_s),
      .term_valid(term_valid_s), .term_index(term_index_s), .overflow(overflow_s)
   );

   // Reference: F(k) mod 2^W, plus whether the true F(k) reaches 2^W
   // (exact value kept saturated well above 2^W so the comparison stays valid).
   function automatic void ref_fib(input int k, output logic [W-1:0] v, output logic ov);
      longint m0 = 0, m1 = 1, t;
      longint e0 = 0, e1 = 1, te;
      longint cap = 64'd1 << 40;
      for (int i = 0; i < k; i++) begin
         t  = (m0 + m1) % (64'd1 << W);
         m0 = m1;
         m1 = t;
         te = e0 + e1;
         if (te > cap) te = cap;
         e0 = e1;
         e1 = te;
      end
      v  = m0[W-1:0];
      ov = (e0 >= (64'd1 << W));
   endfunction

   // Issues one request on the final-result instance and checks latency, value, flag.
   task automatic do_request(input int nv);
      logic [W-1:0] ev;
      logic         eo;
      int           lat;
      ref_fib(nv, ev, eo);
      @(negedge clock);
      start = 1'b1;
      n     = nv[NW-1:0];
      @(posedge clock);
      #1;
      start = 1'b0;
      n     = $urandom_range(0, 255);
      checks++;
      if (busy !== 1'b1) begin
         errors++;
         $display("FAIL busy_accept n=%0d: got %b want 1", nv, busy);
      end
      lat = 0;
      while (done !== 1'b1 && lat < 400) begin
         @(posedge clock);
         #1;
         lat++;
         if (term_valid !== 1'b0) begin
            checks++;
            errors++;
            $display("FAIL term_valid_tied n=%0d: got %b want 0", nv, term_valid);
         end
      end
      checks++;
      if (lat != nv + 1) begin
         errors++;
         $display("FAIL latency n=%0d: got %0d want %0d", nv, lat, nv + 1);
      end
      checks++;
      if (fibonacci !== ev || overflow !== eo || busy !== 1'b1) begin
         errors++;
         $display("FAIL result n=%0d: got fib=%0d ovf=%b busy=%b want fib=%0d ovf=%b busy=1",
                  nv, fibonacci, overflow, busy, ev, eo);
      end
      @(posedge clock);
      #1;
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || fibonacci !== ev) begin
         errors++;
         $display("FAIL after_done n=%0d: got busy=%b done=%b fib=%0d want 0 0 %0d",
                  nv, busy, done, fibonacci, ev);
      end
      $display("request n=%0d latency=%0d fib=%0d ovf=%b (ref %0d %b)",
               nv, lat, fibonacci, overflow, ev, eo);
   endtask

   task automatic test_reset;
      #2;
      checks++;
      if ({busy, done, fibonacci, term_valid, term_index, overflow} !== '0 ||
          {busy_s, done_s, fibonacci_s, term_valid_s, term_index_s, overflow_s} !== '0) begin
         errors++;
         $display("FAIL reset_state: got busy=%b done=%b fib=%0d tv=%b ti=%0d ovf=%b want all 0",
                  busy, done, fibonacci, term_valid, term_index, overflow);
      end
      #8;
      reset = 1'b1;
      $display("reset released");
   endtask

   task automatic test_directed;
      int list[8] = '{10, 0, 1, 2, 13, 14, 20, 255};
      foreach (list[i]) do_request(list[i]);
   endtask

   task automatic test_random;
      for (int i = 0; i < 12; i++) do_request($urandom_range(0, 40));
      for (int i = 0; i < 3; i++) do_request($urandom_range(41, 255));
   endtask

   task automatic run_stream(input int nv);
      logic [W-1:0] ev;
      logic         eo;
      @(negedge clock);
      start_s = 1'b1;
      n_s     = nv[NW-1:0];
      @(posedge clock);
      #1;
      start_s = 1'b0;
      for (int k = 0; k <= nv; k++) begin
         @(posedge clock);
         #1;
         ref_fib(k, ev, eo);
         checks++;
         if (term_valid_s !== 1'b1 || term_index_s !== k[NW-1:0] || fibonacci_s !== ev ||
             overflow_s !== eo || done_s !== (k == nv)) begin
            errors++;
            $display("FAIL stream_term n=%0d k=%0d: got tv=%b idx=%0d fib=%0d ovf=%b done=%b want 1 %0d %0d %b %b",
                     nv, k, term_valid_s, term_index_s, fibonacci_s, overflow_s, done_s,
                     k, ev, eo, k == nv);
         end
      end
      @(posedge clock);
      #1;
      checks++;
      if (term_valid_s !== 1'b0 || done_s !== 1'b0 || busy_s !== 1'b0) begin
         errors++;
         $display("FAIL stream_end n=%0d: got tv=%b done=%b busy=%b want 0 0 0",
                  nv, term_valid_s, done_s, busy_s);
      end
      $display("stream n=%0d emitted %0d terms", nv, nv + 1);
   endtask

   task automatic test_stream;
      run_stream(5);
      run_stream($urandom_range(10, 20));
      run_stream(0);
   endtask

   task automatic test_back_to_back;
      int lat;
      @(negedge clock);
      start = 1'b1;
      n     = 8'd10;
      @(posedge clock);
      #1;
      start = 1'b0;
      repeat (3) @(posedge clock);
      @(negedge clock);
      start = 1'b1;
      n     = 8'd3;
      @(negedge clock);
      start = 1'b0;
      lat = 0;
      while (done !== 1'b1 && lat < 400) begin
         @(posedge clock);
         #1;
         lat++;
      end
      checks++;
      if (fibonacci !== 8'd55 || overflow !== 1'b0) begin
         errors++;
         $display("FAIL ignore_start_calc: got fib=%0d ovf=%b want 55 0", fibonacci, overflow);
      end
      start = 1'b1;
      n     = 8'd3;
      @(posedge clock);
      #1;
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL ignore_start_done: got busy=%b want 0", busy);
      end
      @(posedge clock);
      #1;
      start = 1'b0;
      checks++;
      if (busy !== 1'b1) begin
         errors++;
         $display("FAIL accept_next_idle: got busy=%b want 1", busy);
      end
      lat = 0;
      while (done !== 1'b1 && lat < 400) begin
         @(posedge clock);
         #1;
         lat++;
      end
      checks++;
      if (lat != 4 || fibonacci !== 8'd2) begin
         errors++;
         $display("FAIL back_to_back n=3: got lat=%0d fib=%0d want 4 2", lat, fibonacci);
      end
      @(posedge clock);
      #1;
      $display("back_to_back: ignored mid-run starts, next request fib=%0d", fibonacci);
   endtask

   task automatic test_reset_mid;
      @(negedge clock);
      start = 1'b1;
      n     = 8'd10;
      @(posedge clock);
      #1;
      start = 1'b0;
      repeat (4) @(posedge clock);
      #2;
      reset = 1'b0;
      #1;
      checks++;
      if ({busy, done, fibonacci, term_valid, term_index, overflow} !== '0) begin
         errors++;
         $display("FAIL reset_mid_outputs: got busy=%b done=%b fib=%0d ovf=%b want all 0",
                  busy, done, fibonacci, overflow);
      end
      repeat (2) @(posedge clock);
      @(negedge clock);
      reset = 1'b1;
      repeat (12) begin
         @(posedge clock);
         #1;
         checks++;
         if (done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_no_done: got done=%b busy=%b want 0 0", done, busy);
         end
      end
      $display("reset mid-operation aborted run");
      do_request(7);
   endtask

   initial begin
      test_reset();
      test_directed();
      test_random();
      test_stream();
      test_back_to_back();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
